// File: rtl/display_timings_272p.sv
// Display timing generator for the 480x272 RGB LCD: free-running pixel/line counters
// with registered coordinates, syncs, data enable and line/frame strobes, all aligned.
module display_timings_272p #(
   parameter int unsigned CORDW    = 10,
   parameter int unsigned H_ACTIVE = 480,
   parameter int unsigned H_FP     = 2,
   parameter int unsigned H_SYNC   = 41,
   parameter int unsigned H_BP     = 2,
   parameter int unsigned V_ACTIVE = 272,
   parameter int unsigned V_FP     = 2,
   parameter int unsigned V_SYNC   = 10,
   parameter int unsigned V_BP     = 2,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0
) (
   input  logic             clk_pix_i,
   input  logic             rst_pix_i,
   output logic [CORDW-1:0] sx_o,
   output logic [CORDW-1:0] sy_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             de_o,
   output logic             line_o,
   output logic             frame_o,
   output logic [15:0]      frame_cnt_o
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] HLast   = CORDW'(HTotal - 1);
   localparam logic [CORDW-1:0] VLast   = CORDW'(VTotal - 1);
   localparam logic [CORDW-1:0] HAct    = CORDW'(H_ACTIVE);
   localparam logic [CORDW-1:0] VAct    = CORDW'(V_ACTIVE);
   localparam logic [CORDW-1:0] HsFirst = CORDW'(H_ACTIVE + H_FP);
   localparam logic [CORDW-1:0] HsLast  = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CORDW-1:0] VsFirst = CORDW'(V_ACTIVE + V_FP);
   localparam logic [CORDW-1:0] VsLast  = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic             started_q;
   logic [CORDW-1:0] sx_q, sx_d;
   logic [CORDW-1:0] sy_q, sy_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic             line_q, line_d;
   logic             frame_q, frame_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   // The first edge after reset presents (0,0) instead of advancing, so every output
   // is computed from the next coordinate and registered alongside it.
   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      if (!started_q) begin
         sx_d = '0;
         sy_d = '0;
      end else if (sx_q == HLast) begin
         sx_d = '0;
         sy_d = (sy_q == VLast) ? '0 : sy_q + 1'b1;
      end else begin
         sx_d = sx_q + 1'b1;
      end

      de_d        = (sx_d < HAct) && (sy_d < VAct);
      hsync_d     = ((sx_d >= HsFirst) && (sx_d <= HsLast)) ? H_POL : ~H_POL;
      vsync_d     = ((sy_d >= VsFirst) && (sy_d <= VsLast)) ? V_POL : ~V_POL;
      line_d      = (sx_d == '0);
      frame_d     = line_d && (sy_d == '0);
      frame_cnt_d = frame_cnt_q + {15'd0, frame_d};
   end

   always_ff @(posedge clk_pix_i or posedge rst_pix_i) begin
      if (rst_pix_i) begin
         started_q   <= 1'b0;
         sx_q        <= '0;
         sy_q        <= '0;
         hsync_q     <= ~H_POL;
         vsync_q     <= ~V_POL;
         de_q        <= 1'b0;
         line_q      <= 1'b0;
         frame_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         started_q   <= 1'b1;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         de_q        <= de_d;
         line_q      <= line_d;
         frame_q     <= frame_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign sx_o        = sx_q;
   assign sy_o        = sy_q;
   assign hsync_o     = hsync_q;
   assign vsync_o     = vsync_q;
   assign de_o        = de_q;
   assign line_o      = line_q;
   assign frame_o     = frame_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule
